hub75_bcm_scan_driver: RTL and testbench

Parametrised successor to the single-column HUB75 output path. Autonomously scans all SCAN_RATE row pairs and fetches pixels from a frame-buffer read port with 1-cycle latency. Renders RGB_RES-bit colour with binary-code modulation (BCM) and drives NUM_CHAINS parallel rgb0/rgb1 pairs. Sits between the frame manager's buffer and the panel pins, and replaces external hub75_addr sequencing.

---
 rtl/hub75_pkg.sv | 37 +++
 rtl/hub75_bcm_scan_driver_if.sv | 33 +++
 rtl/bcm_timer.sv | 46 ++++
 rtl/hub75_bcm_scan_driver.sv | 171 +++++++++++++++++
 tb/tb_hub75_bcm_scan_driver.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 BCM scan driver: FSM state encoding,
// bits-per-channel derivation, per-plane pixel bit extraction and plane durations.
package hub75_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_SHIFT   = 3'd2,
    S_BLANK   = 3'd3,
    S_LATCH   = 3'd4,
    S_DISPLAY = 3'd5
  } state_t;

  // Pixels are zero-extended to this width before bit extraction.
  localparam int PIX_MAX = 64;

  function automatic int calc_bpc(input int rgb_res);
    return rgb_res / 3;
  endfunction

  // Returns {R,G,B} bit `plane` of a packed {R,G,B} pixel with bpc bits per channel.
  function automatic logic [2:0] extract_rgb(input logic [PIX_MAX-1:0] pix,
                                             input int bpc, input int plane);
    logic [5:0] ir;
    logic [5:0] ig;
    logic [5:0] ib;
    ir = 6'(2 * bpc + plane);
    ig = 6'(bpc + plane);
    ib = 6'(plane);
    return {pix[ir], pix[ig], pix[ib]};
  endfunction

  function automatic int plane_duration(input int base, input int plane);
    return base << plane;
  endfunction

endpackage

// File: rtl/hub75_bcm_scan_driver_if.sv
// Frame-buffer read port between the scan driver (master) and the pixel store (slave).
interface hub75_bcm_scan_driver_if #(
  parameter int NUM_COLS   = 64,
  parameter int SCAN_RATE  = 32,
  parameter int RGB_RES    = 9,
  parameter int NUM_CHAINS = 1
);

  // pix_rd_en is a single-cycle strobe qualifying pix_row/pix_col; the slave must
  // present pix_top/pix_bot exactly one cycle later. There is no back-pressure.
  logic                             pix_rd_en;
  logic [$clog2(SCAN_RATE)-1:0]     pix_row;
  logic [$clog2(NUM_COLS)-1:0]      pix_col;
  logic [NUM_CHAINS*RGB_RES-1:0]    pix_top;
  logic [NUM_CHAINS*RGB_RES-1:0]    pix_bot;

  modport master (
    output pix_rd_en,
    output pix_row,
    output pix_col,
    input  pix_top,
    input  pix_bot
  );

  modport slave (
    input  pix_rd_en,
    input  pix_row,
    input  pix_col,
    output pix_top,
    output pix_bot
  );

endinterface

// File: rtl/bcm_timer.sv
// Display-phase timer: loaded with a plane duration, runs for duration+1 cycles and
// holds OE low for the on-time. With HUB75_BRIGHTNESS_EN the on-time is scaled.
module bcm_timer #(
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          run,
  input  logic [TW-1:0] duration,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]    brightness,
`endif
  output logic          oe_n,
  output logic          done
);

  logic [TW-1:0] remain;
  logic [TW-1:0] on_left;
  logic [TW-1:0] on_time;

  always_comb begin
    on_time = duration;
`ifdef HUB75_BRIGHTNESS_EN
    on_time = TW'(((TW+8)'(duration) * (TW+8)'(brightness)) >> 8);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remain  <= '0;
      on_left <= '0;
    end else if (load) begin
      remain  <= duration;
      on_left <= on_time;
    end else if (run) begin
      if (remain != '0) remain <= remain - TW'(1);
      if (on_left != '0) on_left <= on_left - TW'(1);
    end
  end

  // The extra cycle at remain==0 is the blanked tail on which DISPLAY exits.
  assign done = run && (remain == '0);
  assign oe_n = !(run && (on_left != '0));

endmodule

// File: rtl/hub75_bcm_scan_driver.sv
// HUB75 panel scan driver with binary-code modulation: fetches a row pair per plane,
// shifts it out, latches and displays. Optional macro: HUB75_BRIGHTNESS_EN.
module hub75_bcm_scan_driver
  import hub75_pkg::*;
#(
  parameter int NUM_COLS   = 64,
  parameter int SCAN_RATE  = 32,
  parameter int RGB_RES    = 9,
  parameter int NUM_CHAINS = 1,
  parameter int CLK_DIV    = 2,
  parameter int BCM_BASE   = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         enable,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]                   brightness,
`endif
  hub75_bcm_scan_driver_if.master      pix,
  output logic [$clog2(SCAN_RATE)-1:0] hub75_addr,
  output logic [3*NUM_CHAINS-1:0]      hub75_rgb0,
  output logic [3*NUM_CHAINS-1:0]      hub75_rgb1,
  output logic                         hub75_latch,
  output logic                         hub75_OE,
  output logic                         hub75_clk,
  output logic                         frame_done,
  output logic                         busy,
  output state_t                       dbg_state
);

  localparam int BPC = calc_bpc(RGB_RES);
  localparam int RW  = $clog2(SCAN_RATE);
  localparam int CW  = $clog2(NUM_COLS);
  localparam int PW  = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int DW  = $clog2(CLK_DIV);
  localparam int TW  = $clog2((BCM_BASE << (BPC - 1)) + 1);

  state_t          state;
  state_t          state_nx;
  logic [RW-1:0]   row;
  logic [PW-1:0]   plane;
  logic [CW-1:0]   col;
  logic [DW-1:0]   div_cnt;
  logic [3*NUM_CHAINS-1:0] rgb0_q;
  logic [3*NUM_CHAINS-1:0] rgb1_q;
  logic [3*NUM_CHAINS-1:0] rgb0_live;
  logic [3*NUM_CHAINS-1:0] rgb1_live;

  logic last_div;
  logic last_col;
  logic last_plane;
  logic last_row;
  logic data_cycle;
  logic plane_end;
  logic tmr_oe_n;
  logic tmr_done;

  assign last_div   = (div_cnt == DW'(CLK_DIV - 1));
  assign last_col   = (col == CW'(NUM_COLS - 1));
  assign last_plane = (plane == PW'(BPC - 1));
  assign last_row   = (row == RW'(SCAN_RATE - 1));
  // Read data for the current column arrives on the first cycle of each pixel.
  assign data_cycle = (state == S_SHIFT) && (div_cnt == '0);
  assign plane_end  = (state == S_DISPLAY) && tmr_done;

  always_comb begin
    rgb0_live = '0;
    rgb1_live = '0;
    for (int k = 0; k < NUM_CHAINS; k++) begin
      rgb0_live[3*k +: 3] = extract_rgb(PIX_MAX'(pix.pix_top[k*RGB_RES +: RGB_RES]), BPC, int'(plane));
      rgb1_live[3*k +: 3] = extract_rgb(PIX_MAX'(pix.pix_bot[k*RGB_RES +: RGB_RES]), BPC, int'(plane));
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (enable) state_nx = S_FETCH;
      S_FETCH:   state_nx = S_SHIFT;
      S_SHIFT:   if (last_col && last_div) state_nx = S_BLANK;
      S_BLANK:   state_nx = S_LATCH;
      S_LATCH:   state_nx = S_DISPLAY;
      S_DISPLAY: if (tmr_done) state_nx = enable ? S_FETCH : S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    pix.pix_rd_en = (state == S_FETCH) ||
                    ((state == S_SHIFT) && last_div && !last_col);
    pix.pix_row   = row;
    pix.pix_col   = (state == S_SHIFT) ? col + CW'(1) : '0;
    hub75_clk     = (state == S_SHIFT) && (div_cnt >= DW'(CLK_DIV / 2));
    hub75_latch   = (state == S_LATCH);
    hub75_OE      = (state == S_DISPLAY) ? tmr_oe_n : 1'b1;
    hub75_rgb0    = data_cycle ? rgb0_live : rgb0_q;
    hub75_rgb1    = data_cycle ? rgb1_live : rgb1_q;
    frame_done    = plane_end && last_plane && last_row;
    busy          = (state != S_IDLE);
    dbg_state     = state;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rgb0_q <= '0;
      rgb1_q <= '0;
    end else if (data_cycle) begin
      rgb0_q <= rgb0_live;
      rgb1_q <= rgb1_live;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      row        <= '0;
      plane      <= '0;
      col        <= '0;
      div_cnt    <= '0;
      hub75_addr <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          col     <= '0;
          div_cnt <= '0;
        end
        S_SHIFT: begin
          if (last_div) begin
            div_cnt <= '0;
            col     <= last_col ? '0 : col + CW'(1);
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        S_BLANK: hub75_addr <= row;
        S_DISPLAY: begin
          // Plane advances even when disabled, so a re-enable resumes at the next plane.
          if (tmr_done) begin
            if (last_plane) begin
              plane <= '0;
              row   <= last_row ? '0 : row + RW'(1);
            end else begin
              plane <= plane + PW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  bcm_timer #(
    .TW(TW)
  ) u_timer (
    .clk        (clk_in),
    .rst        (rst_in),
    .load       (state == S_BLANK),
    .run        (state == S_DISPLAY),
    .duration   (TW'(plane_duration(BCM_BASE, int'(plane)))),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness (brightness),
`endif
    .oe_n       (tmr_oe_n),
    .done       (tmr_done)
  );

endmodule

// File: tb/tb_hub75_bcm_scan_driver.sv
// Directed bench for hub75_bcm_scan_driver on a 4-column, 2-row-pair, 6-bit configuration.
module tb_hub75_bcm_scan_driver;
  import hub75_pkg::*;

  localparam int NUM_COLS   = 4;
  localparam int SCAN_RATE  = 2;
  localparam int RGB_RES    = 6;
  localparam int NUM_CHAINS = 1;
  localparam int CLK_DIV    = 2;
  localparam int BCM_BASE   = 2;
  localparam int BPC        = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0] brightness = 8'd255;
`endif
  logic [0:0] hub75_addr;
  logic [2:0] rgb0;
  logic [2:0] rgb1;
  logic       latch;
  logic       oe;
  logic       hclk;
  logic       frame_done;
  logic       busy;
  state_t     dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int fd_count = 0;
  int fd_last  = -1;
  int fd_gap   = 0;

  logic [5:0] top_mem [2][4];
  logic [5:0] bot_mem [2][4];

  hub75_bcm_scan_driver_if #(
    .NUM_COLS(NUM_COLS), .SCAN_RATE(SCAN_RATE), .RGB_RES(RGB_RES), .NUM_CHAINS(NUM_CHAINS)
  ) pif ();

  hub75_bcm_scan_driver #(
    .NUM_COLS(NUM_COLS), .SCAN_RATE(SCAN_RATE), .RGB_RES(RGB_RES),
    .NUM_CHAINS(NUM_CHAINS), .CLK_DIV(CLK_DIV), .BCM_BASE(BCM_BASE)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .enable      (enable),
`ifdef HUB75_BRIGHTNESS_EN
    .brightness  (brightness),
`endif
    .pix         (pif.master),
    .hub75_addr  (hub75_addr),
    .hub75_rgb0  (rgb0),
    .hub75_rgb1  (rgb1),
    .hub75_latch (latch),
    .hub75_OE    (oe),
    .hub75_clk   (hclk),
    .frame_done  (frame_done),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // Clock / frame-buffer model with one-cycle read latency.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pif.pix_rd_en) begin
      pif.pix_top <= top_mem[pif.pix_row][pif.pix_col];
      pif.pix_bot <= bot_mem[pif.pix_row][pif.pix_col];
    end
  end

  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      if (fd_last >= 0) fd_gap = cyc - fd_last;
      fd_last = cyc;
      fd_count++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent model of the colour bit selection: {R,G,B} bit p of a 2-bit/channel pixel.
  function automatic logic [2:0] exp3(input logic [5:0] px, input int p);
    logic [2:0] ir;
    logic [2:0] ig;
    logic [2:0] ib;
    ir = 3'(2 * BPC + p);
    ig = 3'(BPC + p);
    ib = 3'(p);
    return {px[ir], px[ig], px[ib]};
  endfunction

  function automatic int low_for(input int p);
    int d;
    d = BCM_BASE << p;
`ifdef HUB75_BRIGHTNESS_EN
    return (d * int'(brightness)) >> 8;
`else
    return d;
`endif
  endfunction

  // Walks one plane starting from its FETCH cycle and ends sampling the following cycle.
  task automatic run_plane(input int r, input int p, input int low, input bit last,
                           input int drop_at, input bit use_k,
                           input logic [2:0] k0, input logic [2:0] k1);
    int         dur;
    int         rises;
    bit         rd;
    logic       prev_clk;
    logic [2:0] e0;
    logic [2:0] e1;
    dur = BCM_BASE << p;
    chk("fetch_state", 32'(dbg_state), 32'(S_FETCH));
    chk("fetch_rd_en", 32'(pif.pix_rd_en), 32'd1);
    chk("fetch_col", 32'(pif.pix_col), 32'd0);
    chk("fetch_row", 32'(pif.pix_row), 32'(r));
    chk("fetch_oe", 32'(oe), 32'd1);
    prev_clk = hclk;
    rises = 0;
    for (int i = 0; i < NUM_COLS * CLK_DIV; i++) begin
      step();
      if (i == drop_at) enable = 1'b0;
      e0 = use_k ? k0 : exp3(top_mem[r][i / CLK_DIV], p);
      e1 = use_k ? k1 : exp3(bot_mem[r][i / CLK_DIV], p);
      rd = ((i % CLK_DIV) == CLK_DIV - 1) && ((i / CLK_DIV) < NUM_COLS - 1);
      chk("shift_state", 32'(dbg_state), 32'(S_SHIFT));
      chk("shift_clk", 32'(hclk), 32'(i % CLK_DIV));
      chk("shift_rgb0", 32'(rgb0), 32'(e0));
      chk("shift_rgb1", 32'(rgb1), 32'(e1));
      chk("shift_rd_en", 32'(pif.pix_rd_en), 32'(rd));
      if (rd) chk("shift_col", 32'(pif.pix_col), 32'(i / CLK_DIV + 1));
      chk("shift_oe", 32'(oe), 32'd1);
      if (hclk && !prev_clk) rises++;
      prev_clk = hclk;
    end
    chk("clk_rises", 32'(rises), 32'(NUM_COLS));
    step();
    chk("blank_state", 32'(dbg_state), 32'(S_BLANK));
    chk("blank_oe", 32'(oe), 32'd1);
    chk("blank_latch", 32'(latch), 32'd0);
    step();
    chk("latch_state", 32'(dbg_state), 32'(S_LATCH));
    chk("latch_pulse", 32'(latch), 32'd1);
    chk("latch_oe", 32'(oe), 32'd1);
    chk("latch_addr", 32'(hub75_addr), 32'(r));
    chk("latch_pix_row", 32'(pif.pix_row), 32'(r));
    for (int j = 0; j < dur; j++) begin
      step();
      chk("disp_state", 32'(dbg_state), 32'(S_DISPLAY));
      chk("disp_latch", 32'(latch), 32'd0);
      chk("disp_oe", 32'(oe), (j < low) ? 32'd0 : 32'd1);
      chk("disp_frame_done", 32'(frame_done), 32'd0);
    end
    step();
    chk("tail_state", 32'(dbg_state), 32'(S_DISPLAY));
    chk("tail_oe", 32'(oe), 32'd1);
    chk("tail_frame_done", 32'(frame_done), 32'(last));
    step();
  endtask

  initial begin
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        top_mem[r][c] = 6'b11_00_01;
        bot_mem[r][c] = 6'b00_11_10;
      end
    end

    // Reset state
    rst = 1'b1;
    enable = 1'b1;
    repeat (3) step();
    chk("rst_oe", 32'(oe), 32'd1);
    chk("rst_latch", 32'(latch), 32'd0);
    chk("rst_clk", 32'(hclk), 32'd0);
    chk("rst_rgb0", 32'(rgb0), 32'd0);
    chk("rst_rgb1", 32'(rgb1), 32'd0);
    chk("rst_addr", 32'(hub75_addr), 32'd0);
    chk("rst_rd_en", 32'(pif.pix_rd_en), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0;
    step();

    // Frame 1: uniform pixels, hand-computed colour bits
    run_plane(0, 0, low_for(0), 1'b0, -1, 1'b1, 3'b101, 3'b010);
    run_plane(0, 1, low_for(1), 1'b0, -1, 1'b1, 3'b100, 3'b011);
    run_plane(1, 0, low_for(0), 1'b0, -1, 1'b1, 3'b101, 3'b010);
    run_plane(1, 1, low_for(1), 1'b1, -1, 1'b1, 3'b100, 3'b011);
    chk("frame1_count", 32'(fd_count), 32'd1);

    // Frame 2: distinct pixel per column so ordering on rgb is visible
    top_mem[0][0] = 6'h05; top_mem[0][1] = 6'h1A; top_mem[0][2] = 6'h2C; top_mem[0][3] = 6'h33;
    top_mem[1][0] = 6'h3E; top_mem[1][1] = 6'h01; top_mem[1][2] = 6'h12; top_mem[1][3] = 6'h24;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) bot_mem[r][c] = ~top_mem[r][c];
    end
    run_plane(0, 0, low_for(0), 1'b0, -1, 1'b0, 3'b000, 3'b000);
    run_plane(0, 1, low_for(1), 1'b0, -1, 1'b0, 3'b000, 3'b000);
    run_plane(1, 0, low_for(0), 1'b0, -1, 1'b0, 3'b000, 3'b000);
    run_plane(1, 1, low_for(1), 1'b1, -1, 1'b0, 3'b000, 3'b000);
    chk("frame2_count", 32'(fd_count), 32'd2);
    chk("frame_period", 32'(fd_gap), 32'd60);

    // Enable dropped mid-shift of row 1 plane 0
    run_plane(0, 0, low_for(0), 1'b0, -1, 1'b0, 3'b000, 3'b000);
    run_plane(0, 1, low_for(1), 1'b0, -1, 1'b0, 3'b000, 3'b000);
    run_plane(1, 0, low_for(0), 1'b0, 3, 1'b0, 3'b000, 3'b000);
    for (int i = 0; i < 4; i++) begin
      chk("idle_state", 32'(dbg_state), 32'(S_IDLE));
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_oe", 32'(oe), 32'd1);
      step();
    end
    enable = 1'b1;
    step();
    run_plane(1, 1, low_for(1), 1'b1, -1, 1'b0, 3'b000, 3'b000);

    // Reset in the middle of DISPLAY of row 1
    run_plane(0, 0, low_for(0), 1'b0, -1, 1'b0, 3'b000, 3'b000);
    run_plane(0, 1, low_for(1), 1'b0, -1, 1'b0, 3'b000, 3'b000);
    repeat (1 + NUM_COLS * CLK_DIV + 2) step();
    chk("pre_rst_state", 32'(dbg_state), 32'(S_DISPLAY));
    chk("pre_rst_addr", 32'(hub75_addr), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_oe", 32'(oe), 32'd1);
    chk("mid_rst_latch", 32'(latch), 32'd0);
    chk("mid_rst_addr", 32'(hub75_addr), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rgb0", 32'(rgb0), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
    step();
    step();
    rst = 1'b0;
    step();
    run_plane(0, 0, low_for(0), 1'b0, -1, 1'b0, 3'b000, 3'b000);

`ifdef HUB75_BRIGHTNESS_EN
    // Brightness scaling: 4-cycle plane at 128 -> 2 low cycles; 0 -> never low
    brightness = 8'd128;
    run_plane(0, 1, 2, 1'b0, -1, 1'b0, 3'b000, 3'b000);
    brightness = 8'd0;
    run_plane(1, 0, 0, 1'b0, -1, 1'b0, 3'b000, 3'b000);
    run_plane(1, 1, 0, 1'b1, -1, 1'b0, 3'b000, 3'b000);
    brightness = 8'd255;
`else
    run_plane(0, 1, low_for(1), 1'b0, -1, 1'b0, 3'b000, 3'b000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
